// File: rtl/cvo_frame_monitor.sv
// Passive monitor behind the clocked-video output: measures active geometry per frame,
// checks line-length consistency, tracks geometry lock and counts frames/underflows.
module cvo_frame_monitor #(
  parameter int unsigned CNT_W            = 12,
  parameter int unsigned STAT_W           = 16,
  parameter int unsigned STABLE_FRAMES    = 2,
  parameter int unsigned SYNC_ACTIVE_HIGH = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [23:0]       vid_data,
  input  logic              vid_datavalid,
  input  logic              vid_h_sync,
  input  logic              vid_v_sync,
  input  logic              vid_underflow,
  input  logic              clear,
  output logic [CNT_W-1:0]  frame_width,
  output logic [CNT_W-1:0]  frame_height,
  output logic              frame_valid,
  output logic              line_err,
  output logic              locked,
  output logic [STAT_W-1:0] frame_count,
  output logic [STAT_W-1:0] underflow_count,
  output logic [23:0]       last_pixel
);

  localparam int unsigned PIX_W    = 24;
  localparam int unsigned STB_W    = 4;
  localparam logic        SYNC_INV = (SYNC_ACTIVE_HIGH == 0);

  typedef enum logic [1:0] {WAIT_VS, ACTIVE, PUBLISH} state_t;

  state_t             state;
  logic [PIX_W-1:0]   data_q;
  logic               dv_q, hs_q, vs_q, uf_q, clr_q;
  logic               dv_prev, hs_prev, vs_prev, uf_prev;
  logic [CNT_W-1:0]   pix_cnt, line_cnt, ref_width;
  logic               err_acc;
  logic [PIX_W-1:0]   shadow;
  logic [STB_W-1:0]   stable_cnt;
  logic               have_prev;

  logic               vs_rise, dv_fall, hs_rise, uf_rise, eol;
  logic [CNT_W-1:0]   pix_inc, pix_n, lc_n, rw_n;
  logic               err_n, geom_match;
  logic [STB_W-1:0]   stb_n;

  // Single input register stage; syncs normalised to active-high
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= '0;
      dv_q    <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      uf_q    <= 1'b0;
      clr_q   <= 1'b0;
      dv_prev <= 1'b0;
      hs_prev <= 1'b0;
      vs_prev <= 1'b0;
      uf_prev <= 1'b0;
    end else begin
      data_q  <= vid_data;
      dv_q    <= vid_datavalid;
      hs_q    <= vid_h_sync ^ SYNC_INV;
      vs_q    <= vid_v_sync ^ SYNC_INV;
      uf_q    <= vid_underflow;
      clr_q   <= clear;
      dv_prev <= dv_q;
      hs_prev <= hs_q;
      vs_prev <= vs_q;
      uf_prev <= uf_q;
    end
  end

  assign vs_rise = vs_q & ~vs_prev;
  assign dv_fall = dv_prev & ~dv_q;
  assign hs_rise = hs_q & ~hs_prev;
  assign uf_rise = uf_q & ~uf_prev;
  assign pix_inc = (pix_cnt == '1) ? pix_cnt : pix_cnt + CNT_W'(1);
  // An h_sync edge inside a run of valid pixels also closes the line
  assign eol     = (pix_cnt != '0) && (dv_fall || (hs_rise && dv_q));

  // Accumulator values with any line end in this cycle already folded in
  always_comb begin
    lc_n  = line_cnt;
    rw_n  = ref_width;
    err_n = err_acc;
    pix_n = dv_q ? pix_inc : pix_cnt;
    if (eol) begin
      lc_n  = (line_cnt == '1) ? line_cnt : line_cnt + CNT_W'(1);
      pix_n = dv_q ? CNT_W'(1) : '0;
      if (line_cnt == '0) begin
        rw_n = pix_cnt;
      end else if (pix_cnt != ref_width) begin
        err_n = 1'b1;
      end
    end
    geom_match = have_prev && (rw_n == frame_width) && (lc_n == frame_height);
    if (err_n) begin
      stb_n = '0;
    end else if (geom_match) begin
      stb_n = (stable_cnt >= STB_W'(STABLE_FRAMES)) ? STB_W'(STABLE_FRAMES)
                                                    : stable_cnt + STB_W'(1);
    end else begin
      stb_n = STB_W'(1);
    end
  end

  // Frame FSM; results load on the v_sync edge so the strobe marks the PUBLISH cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= WAIT_VS;
      pix_cnt         <= '0;
      line_cnt        <= '0;
      ref_width       <= '0;
      err_acc         <= 1'b0;
      shadow          <= '0;
      frame_width     <= '0;
      frame_height    <= '0;
      frame_valid     <= 1'b0;
      line_err        <= 1'b0;
      last_pixel      <= '0;
      frame_count     <= '0;
      underflow_count <= '0;
      stable_cnt      <= '0;
      locked          <= 1'b0;
      have_prev       <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      case (state)
        WAIT_VS: begin
          if (vs_rise) begin
            state     <= ACTIVE;
            pix_cnt   <= '0;
            line_cnt  <= '0;
            ref_width <= '0;
            err_acc   <= 1'b0;
          end
        end
        ACTIVE: begin
          if (dv_q) begin
            shadow <= data_q;
          end
          if (vs_rise) begin
            state     <= PUBLISH;
            pix_cnt   <= '0;
            line_cnt  <= '0;
            ref_width <= '0;
            err_acc   <= 1'b0;
            if (lc_n != '0) begin
              frame_width  <= rw_n;
              frame_height <= lc_n;
              line_err     <= err_n;
              last_pixel   <= shadow;
              frame_valid  <= 1'b1;
              stable_cnt   <= stb_n;
              locked       <= (stb_n >= STB_W'(STABLE_FRAMES));
              have_prev    <= 1'b1;
              if (frame_count != '1) begin
                frame_count <= frame_count + STAT_W'(1);
              end
            end
          end else begin
            pix_cnt   <= pix_n;
            line_cnt  <= lc_n;
            ref_width <= rw_n;
            err_acc   <= err_n;
          end
        end
        PUBLISH: begin
          state <= ACTIVE;
        end
        default: begin
          state <= WAIT_VS;
        end
      endcase

      if (uf_rise && (underflow_count != '1)) begin
        underflow_count <= underflow_count + STAT_W'(1);
      end

      // clear overrides any same-cycle statistics update
      if (clr_q) begin
        frame_count     <= '0;
        underflow_count <= '0;
        stable_cnt      <= '0;
        locked          <= 1'b0;
        have_prev       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cvo_frame_monitor.sv
// Randomised bench for cvo_frame_monitor: drives synthetic active-low video frames and
// checks published geometry, lock, counters and strobe timing against a frame-level model.
module tb_cvo_frame_monitor;

  localparam int SF = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [23:0] vid_data = '0;
  logic        vid_datavalid = 1'b0;
  logic        vid_h_sync = 1'b1;
  logic        vid_v_sync = 1'b1;
  logic        vid_underflow = 1'b0;
  logic        clear = 1'b0;

  logic [11:0] frame_width, frame_height;
  logic        frame_valid, line_err, locked;
  logic [15:0] frame_count, underflow_count;
  logic [23:0] last_pixel;

  logic [11:0] s_frame_width, s_frame_height;
  logic        s_frame_valid, s_line_err, s_locked;
  logic [3:0]  s_frame_count, s_underflow_count;
  logic [23:0] s_last_pixel;

  cvo_frame_monitor #(.CNT_W(12), .STAT_W(16), .STABLE_FRAMES(SF), .SYNC_ACTIVE_HIGH(0)) u_dut (
    .clk(clk), .reset_n(reset_n), .vid_data(vid_data), .vid_datavalid(vid_datavalid),
    .vid_h_sync(vid_h_sync), .vid_v_sync(vid_v_sync), .vid_underflow(vid_underflow),
    .clear(clear), .frame_width(frame_width), .frame_height(frame_height),
    .frame_valid(frame_valid), .line_err(line_err), .locked(locked),
    .frame_count(frame_count), .underflow_count(underflow_count), .last_pixel(last_pixel)
  );

  // Narrow-counter instance so saturation is reachable in a short run
  cvo_frame_monitor #(.CNT_W(12), .STAT_W(4), .STABLE_FRAMES(SF), .SYNC_ACTIVE_HIGH(0)) u_sat (
    .clk(clk), .reset_n(reset_n), .vid_data(vid_data), .vid_datavalid(vid_datavalid),
    .vid_h_sync(vid_h_sync), .vid_v_sync(vid_v_sync), .vid_underflow(vid_underflow),
    .clear(clear), .frame_width(s_frame_width), .frame_height(s_frame_height),
    .frame_valid(s_frame_valid), .line_err(s_line_err), .locked(s_locked),
    .frame_count(s_frame_count), .underflow_count(s_underflow_count), .last_pixel(s_last_pixel)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {int w; int h; bit err;} pub_t;
  pub_t        hist[$];
  int          m_w, m_h;
  bit          m_err;
  logic [23:0] m_pix;
  bit          m_armed;
  int          m_count, m_ufl, s_ufl;
  int          e_w, e_h;
  bit          e_err, e_locked;
  logic [23:0] e_pix;

  // Locked when the newest SF published frames are all clean and share one geometry
  function automatic bit model_locked();
    if (hist.size() < SF) return 1'b0;
    for (int i = hist.size() - SF; i < hist.size(); i++)
      if (hist[i].err || hist[i].w != hist[hist.size()-1].w || hist[i].h != hist[hist.size()-1].h)
        return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_h = 0; m_w = 0; m_err = 0; m_armed = 0; m_count = 0; m_ufl = 0; s_ufl = 0;
    e_w = 0; e_h = 0; e_err = 0; e_locked = 0; e_pix = '0;
  endtask

  task automatic drive_frame(input int widths[$], input bit hold_last);
    for (int l = 0; l < widths.size(); l++) begin
      bit use_hs = ($urandom_range(0, 3) != 0);
      @(negedge clk); vid_h_sync = use_hs ? 1'b0 : 1'b1;
      @(negedge clk); vid_h_sync = 1'b1;
      @(negedge clk);
      for (int p = 0; p < widths[l]; p++) begin
        @(negedge clk); vid_datavalid = 1'b1; vid_data = 24'($urandom); m_pix = vid_data;
      end
      if (!(hold_last && l == widths.size() - 1)) begin
        @(negedge clk); vid_datavalid = 1'b0; vid_data = 24'($urandom);
        @(negedge clk);
      end
    end
    m_w = widths[0];
    m_h = widths.size();
    m_err = 0;
    foreach (widths[i]) if (widths[i] != widths[0]) m_err = 1;
  endtask

  task automatic vsync_edge(input bit with_clear);
    bit exp_pub = m_armed && (m_h != 0);
    @(negedge clk); vid_v_sync = 1'b0; vid_datavalid = 1'b0; clear = with_clear;
    @(posedge clk); #1;
    n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL fv_early: got %0b expected 0", frame_valid); end
    @(negedge clk); clear = 1'b0;
    @(posedge clk); #1;
    if (exp_pub) begin
      pub_t f;
      f.w = m_w; f.h = m_h; f.err = m_err;
      hist.push_back(f);
      e_w = m_w; e_h = m_h; e_err = m_err; e_pix = m_pix;
      e_locked = model_locked();
      m_count = (m_count < 65535) ? m_count + 1 : m_count;
    end
    if (with_clear) begin
      hist.delete(); e_locked = 0; m_count = 0; m_ufl = 0; s_ufl = 0;
    end
    m_armed = 1; m_h = 0; m_err = 0;
    n_cmp++; if (frame_valid !== exp_pub) begin n_bad++; $display("FAIL fv_strobe: got %0b expected %0b", frame_valid, exp_pub); end
    n_cmp++; if (frame_width !== 12'(e_w)) begin n_bad++; $display("FAIL width: got %0d expected %0d", frame_width, e_w); end
    n_cmp++; if (frame_height !== 12'(e_h)) begin n_bad++; $display("FAIL height: got %0d expected %0d", frame_height, e_h); end
    n_cmp++; if (line_err !== e_err) begin n_bad++; $display("FAIL line_err: got %0b expected %0b", line_err, e_err); end
    n_cmp++; if (last_pixel !== e_pix) begin n_bad++; $display("FAIL last_pixel: got %06h expected %06h", last_pixel, e_pix); end
    n_cmp++; if (locked !== e_locked) begin n_bad++; $display("FAIL locked: got %0b expected %0b", locked, e_locked); end
    n_cmp++; if (frame_count !== 16'(m_count)) begin n_bad++; $display("FAIL frame_count: got %0d expected %0d", frame_count, m_count); end
    n_cmp++; if (underflow_count !== 16'(m_ufl)) begin n_bad++; $display("FAIL ufl_after_vs: got %0d expected %0d", underflow_count, m_ufl); end
    @(posedge clk); #1;
    n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL fv_width: got %0b expected 0", frame_valid); end
    @(negedge clk); vid_v_sync = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_uf(input int len);
    @(negedge clk); vid_underflow = 1'b1;
    repeat (len - 1) @(negedge clk);
    @(negedge clk); vid_underflow = 1'b0;
    repeat (2) @(negedge clk);
    if (m_ufl < 65535) m_ufl++;
    if (s_ufl < 15) s_ufl++;
  endtask

  task automatic do_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    repeat (2) @(negedge clk);
    hist.delete(); e_locked = 0; m_count = 0; m_ufl = 0; s_ufl = 0;
    n_cmp++; if (frame_count !== 16'd0 || locked !== 1'b0 || underflow_count !== 16'd0)
      begin n_bad++; $display("FAIL clear_stats: got fc=%0d lk=%0b uf=%0d expected 0", frame_count, locked, underflow_count); end
    n_cmp++; if (frame_width !== 12'(e_w) || frame_height !== 12'(e_h))
      begin n_bad++; $display("FAIL clear_geom: got %0dx%0d expected %0dx%0d", frame_width, frame_height, e_w, e_h); end
  endtask

  task automatic check_idle_zero(input string tag);
    n_cmp++;
    if (frame_width !== 0 || frame_height !== 0 || frame_valid !== 0 || line_err !== 0 ||
        locked !== 0 || frame_count !== 0 || underflow_count !== 0 || last_pixel !== 0) begin
      n_bad++;
      $display("FAIL %s: got w=%0d h=%0d fv=%0b le=%0b lk=%0b fc=%0d uf=%0d px=%06h expected all 0",
               tag, frame_width, frame_height, frame_valid, line_err, locked, frame_count, underflow_count, last_pixel);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk); #1;
    check_idle_zero("reset_outputs");
    @(negedge clk); reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_clean_frames();
    int q[$];
    vsync_edge(0);
    for (int f = 0; f < 3; f++) begin
      q.delete();
      repeat (12) q.push_back(32);
      drive_frame(q, 0);
      vsync_edge(0);
    end
  endtask

  task automatic test_line_err();
    int q[$];
    repeat (12) q.push_back(32);
    q[5] = 31;
    drive_frame(q, 0);
    vsync_edge(0);
    q[5] = 32;
    for (int f = 0; f < 2; f++) begin
      drive_frame(q, 0);
      vsync_edge(0);
    end
  endtask

  task automatic test_underflow();
    int base = m_ufl;
    for (int i = 0; i < 5; i++) pulse_uf(1);
    pulse_uf(10);
    n_cmp++; if (underflow_count !== 16'(base + 6)) begin n_bad++; $display("FAIL ufl_six: got %0d expected %0d", underflow_count, base + 6); end
    do_clear();
    for (int i = 0; i < 14; i++) pulse_uf($urandom_range(1, 3));
    n_cmp++; if (s_underflow_count !== 4'hE) begin n_bad++; $display("FAIL ufl_presat: got %0h expected e", s_underflow_count); end
    for (int i = 0; i < 3; i++) pulse_uf(1);
    n_cmp++; if (s_underflow_count !== 4'hF) begin n_bad++; $display("FAIL ufl_sat: got %0h expected f", s_underflow_count); end
    n_cmp++; if (underflow_count !== 16'(m_ufl)) begin n_bad++; $display("FAIL ufl_wide: got %0d expected %0d", underflow_count, m_ufl); end
  endtask

  task automatic test_same_cycle_and_clear();
    int q[$];
    repeat (3) q.push_back(4);
    drive_frame(q, 1);
    vsync_edge(0);
    q.delete();
    repeat (6) q.push_back(20);
    drive_frame(q, 0);
    vsync_edge(1);
    drive_frame(q, 0);
    vsync_edge(0);
  endtask

  task automatic test_empty_frames();
    vsync_edge(0);
    vsync_edge(0);
  endtask

  task automatic test_reset_mid_frame();
    int q[$];
    repeat (5) q.push_back(16);
    drive_frame(q, 0);
    for (int p = 0; p < 7; p++) begin
      @(negedge clk); vid_datavalid = 1'b1; vid_data = 24'($urandom);
    end
    @(negedge clk); reset_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check_idle_zero("reset_mid_line");
    @(negedge clk); vid_datavalid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    q.delete();
    repeat (4) q.push_back(16);
    drive_frame(q, 0);
    vsync_edge(0);
    q.delete();
    repeat (8) q.push_back(12);
    drive_frame(q, 0);
    vsync_edge(0);
  endtask

  task automatic test_random_frames();
    int q[$];
    int w = 10, h = 5;
    for (int f = 0; f < 8; f++) begin
      if ($urandom_range(0, 2) == 0) begin
        w = $urandom_range(4, 24);
        h = $urandom_range(2, 10);
      end
      q.delete();
      repeat (h) q.push_back(w);
      if ($urandom_range(0, 3) == 0) q[$urandom_range(1, h - 1)] = w + $urandom_range(1, 3);
      drive_frame(q, $urandom_range(0, 1));
      vsync_edge(0);
    end
  endtask

  initial begin
    test_reset();
    test_clean_frames();
    test_line_err();
    test_underflow();
    test_same_cycle_and_clear();
    test_empty_frames();
    test_reset_mid_frame();
    test_random_frames();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
